// File: rtl/pipe_pkg.sv
// Types and constants shared by the hazard unit, its forwarding comparator and its interface.
package pipe_pkg;
    localparam int FWD_SEL_W = 3;
    localparam logic [FWD_SEL_W-1:0] FWD_SEL_RF = '0;
    // Stage entries carry the widest supported register index; narrower REG_BITS zero-extend.
    localparam int RD_W = 8;

    typedef struct packed {
        logic [RD_W-1:0] rd;
        logic            wr;
        logic            ld;
    } stage_entry_t;
endpackage

// File: rtl/pipe_hazard_unit_if.sv
// Decode-side handshake between the issue stage and the hazard unit.
interface pipe_hazard_unit_if #(parameter int REG_BITS = 5);
    logic                           id_valid;
    logic [REG_BITS-1:0]            id_rs1;
    logic [REG_BITS-1:0]            id_rs2;
    logic [REG_BITS-1:0]            id_rd;
    logic                           id_regwrite;
    logic                           id_is_load;
    logic                           ex_branch_taken;
    logic                           stall;
    logic                           kill;
    logic [pipe_pkg::FWD_SEL_W-1:0] fwd_sel1;
    logic [pipe_pkg::FWD_SEL_W-1:0] fwd_sel2;
    logic                           wb_en;
    logic [REG_BITS-1:0]            wb_rd;
    logic [31:0]                    perf_stall;
    logic [31:0]                    perf_flush;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_is_load, ex_branch_taken,
        input  stall, kill, fwd_sel1, fwd_sel2, wb_en, wb_rd, perf_stall, perf_flush
    );
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_is_load, ex_branch_taken,
        output stall, kill, fwd_sel1, fwd_sel2, wb_en, wb_rd, perf_stall, perf_flush
    );
endinterface

// File: rtl/pipe_fwd_match.sv
// One source operand against the in-flight writers: youngest match selects the forward
// stage and flags a load result that is not yet available.
module pipe_fwd_match
    import pipe_pkg::*;
#(
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_LAT  = 2
) (
    input  logic [RD_W-1:0]               rs,
    input  stage_entry_t [FWD_DEPTH-1:0]  stages,
    output logic [FWD_SEL_W-1:0]          fwd_sel,
    output logic                          load_haz
);
    // Walk oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        fwd_sel  = FWD_SEL_RF;
        load_haz = 1'b0;
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (rs != '0 && stages[k-1].wr && stages[k-1].rd == rs) begin
                fwd_sel  = FWD_SEL_W'(k);
                load_haz = stages[k-1].ld && (k < LOAD_LAT);
            end
        end
    end
endmodule

// File: rtl/pipe_hazard_unit.sv
// In-order pipeline hazard unit: operand forwarding, load-use stall and branch flush.
// Define PIPE_HAZARD_PERF_EN to build the stall/flush event counters.
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_BITS    = 5,
    parameter int FWD_DEPTH   = 2,
    parameter int LOAD_LAT    = 2,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_unit_if.slave bus
);
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_DEPTH);

    stage_entry_t [FWD_DEPTH-1:0] stage_q;
    logic [2:0]                   flush_cnt_q;
    logic                         kill;
    logic                         stall;
    logic                         haz1;
    logic                         haz2;
    logic [RD_W-1:0]              rs1_x;
    logic [RD_W-1:0]              rs2_x;

    assign rs1_x = RD_W'(bus.id_rs1);
    assign rs2_x = RD_W'(bus.id_rs2);

    pipe_fwd_match #(.FWD_DEPTH(FWD_DEPTH), .LOAD_LAT(LOAD_LAT)) u_match1 (
        .rs(rs1_x), .stages(stage_q), .fwd_sel(bus.fwd_sel1), .load_haz(haz1)
    );
    pipe_fwd_match #(.FWD_DEPTH(FWD_DEPTH), .LOAD_LAT(LOAD_LAT)) u_match2 (
        .rs(rs2_x), .stages(stage_q), .fwd_sel(bus.fwd_sel2), .load_haz(haz2)
    );

    assign kill  = (flush_cnt_q != '0);
    assign stall = bus.id_valid & ~kill & (haz1 | haz2);

    // A branch issued inside the flush shadow is itself killed and must not re-arm the counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt_q <= '0;
        end else if (bus.ex_branch_taken && !kill) begin
            flush_cnt_q <= FLUSH_LOAD;
        end else if (kill) begin
            flush_cnt_q <= flush_cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            if (stall) begin
                stage_q[0] <= '0;
            end else begin
                stage_q[0] <= '{rd: RD_W'(bus.id_rd),
                                wr: bus.id_regwrite & bus.id_valid & ~kill,
                                ld: bus.id_is_load};
            end
            for (int k = 1; k < FWD_DEPTH; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign bus.stall = stall;
    assign bus.kill  = kill;
    assign bus.wb_en = stage_q[FWD_DEPTH-1].wr;
    assign bus.wb_rd = stage_q[FWD_DEPTH-1].rd[REG_BITS-1:0];

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (stall) perf_stall_q <= perf_stall_q + 32'd1;
            if (kill)  perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign bus.perf_stall = perf_stall_q;
    assign bus.perf_flush = perf_flush_q;
`else
    assign bus.perf_stall = '0;
    assign bus.perf_flush = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: directed scenarios plus randomized traffic
// against a cycle-history reference model.
module tb_pipe_hazard_unit;
    localparam int RB = 5;
    localparam int FD = 2;
    localparam int LL = 2;
    localparam int FL = 2;
`ifdef PIPE_HAZARD_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_unit_if #(.REG_BITS(RB)) bus ();

    pipe_hazard_unit #(.REG_BITS(RB), .FWD_DEPTH(FD), .LOAD_LAT(LL), .FLUSH_DEPTH(FL)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    int checks = 0;
    int failures = 0;

    // Issue history indexed by cycle number: what each cycle placed into the pipeline.
    int           cyc;
    bit           lg_wr [256];
    logic [RB-1:0] lg_rd [256];
    bit           lg_ld [256];
    int           kill_start, kill_last;
    int           perf_s, perf_f;

    bit           in_v, in_rw, in_ld, in_br;
    logic [RB-1:0] in_rd;
    bit           e_kill, e_stall, e_wb;
    logic [2:0]   e_f1, e_f2;
    logic [RB-1:0] e_wbrd;

    function automatic int hidx(int k);
        return (cyc - k) & 255;
    endfunction

    function automatic int fwd_of(logic [RB-1:0] rs);
        if (rs == '0) return 0;
        for (int k = 1; k <= FD; k++)
            if (lg_wr[hidx(k)] && lg_rd[hidx(k)] == rs) return k;
        return 0;
    endfunction

    function automatic bit haz_of(logic [RB-1:0] rs);
        int k;
        k = fwd_of(rs);
        return (k != 0) && lg_ld[hidx(k)] && (k < LL);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 256; i++) begin
            lg_wr[i] = 1'b0; lg_rd[i] = '0; lg_ld[i] = 1'b0;
        end
        cyc = 0; kill_start = -10; kill_last = -10; perf_s = 0; perf_f = 0;
    endtask

    task automatic set_in(bit v, logic [RB-1:0] r1, logic [RB-1:0] r2, logic [RB-1:0] rd,
                          bit rw, bit ld, bit br);
        bus.id_valid = v; bus.id_rs1 = r1; bus.id_rs2 = r2; bus.id_rd = rd;
        bus.id_regwrite = rw; bus.id_is_load = ld; bus.ex_branch_taken = br;
        in_v = v; in_rd = rd; in_rw = rw; in_ld = ld; in_br = br;
        @(negedge clk);
        e_kill  = (cyc > kill_start) && (cyc <= kill_last);
        e_f1    = 3'(fwd_of(r1));
        e_f2    = 3'(fwd_of(r2));
        e_stall = v && !e_kill && (haz_of(r1) || haz_of(r2));
        e_wb    = lg_wr[hidx(FD)];
        e_wbrd  = lg_rd[hidx(FD)];
    endtask

    task automatic tick();
        int i;
        i = cyc & 255;
        lg_wr[i] = !e_stall && in_v && in_rw && !e_kill;
        lg_rd[i] = e_stall ? '0 : in_rd;
        lg_ld[i] = e_stall ? 1'b0 : in_ld;
        if (in_br && !e_kill) begin
            kill_start = cyc; kill_last = cyc + FL;
        end
        if (e_stall) perf_s++;
        if (e_kill)  perf_f++;
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            set_in(0, '0, '0, '0, 0, 0, 0);
            tick();
        end
    endtask

    task automatic test_reset();
        set_in_nowait();
        #2;
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %0b want 0", bus.stall); end
        checks++; if (bus.kill !== 1'b0) begin failures++; $display("FAIL reset_kill: got %0b want 0", bus.kill); end
        checks++; if (bus.wb_en !== 1'b0) begin failures++; $display("FAIL reset_wb_en: got %0b want 0", bus.wb_en); end
        checks++; if (bus.fwd_sel1 !== 3'd0 || bus.fwd_sel2 !== 3'd0) begin failures++; $display("FAIL reset_fwd: got %0d/%0d want 0/0", bus.fwd_sel1, bus.fwd_sel2); end
        checks++; if (bus.perf_stall !== 32'd0 || bus.perf_flush !== 32'd0) begin failures++; $display("FAIL reset_perf: got %0d/%0d want 0/0", bus.perf_stall, bus.perf_flush); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic set_in_nowait();
        bus.id_valid = 0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rd = '0;
        bus.id_regwrite = 0; bus.id_is_load = 0; bus.ex_branch_taken = 0;
    endtask

    task automatic test_fwd_alu();
        idle(3);
        set_in(1, 0, 0, 5, 1, 0, 0);
        checks++; if (bus.fwd_sel1 !== 3'd0) begin failures++; $display("FAIL alu_no_fwd: got %0d want 0", bus.fwd_sel1); end
        tick();
        set_in(1, 5, 0, 0, 0, 0, 0);
        checks++; if (bus.fwd_sel1 !== 3'd1) begin failures++; $display("FAIL alu_fwd1: got %0d want 1", bus.fwd_sel1); end
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL alu_stall: got %0b want 0", bus.stall); end
        tick();
        set_in(1, 0, 5, 0, 0, 0, 0);
        checks++; if (bus.fwd_sel2 !== 3'd2) begin failures++; $display("FAIL alu_fwd2: got %0d want 2", bus.fwd_sel2); end
        checks++; if (bus.wb_en !== 1'b1 || bus.wb_rd !== 5'd5) begin failures++; $display("FAIL alu_wb: got en=%0b rd=%0d want en=1 rd=5", bus.wb_en, bus.wb_rd); end
        tick();
    endtask

    task automatic test_load_stall();
        idle(3);
        set_in(1, 0, 0, 7, 1, 1, 0);
        tick();
        set_in(1, 7, 0, 8, 1, 0, 0);
        checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL load_stall_on: got %0b want 1", bus.stall); end
        tick();
        set_in(1, 7, 0, 8, 1, 0, 0);
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL load_stall_off: got %0b want 0", bus.stall); end
        checks++; if (bus.fwd_sel1 !== 3'd2) begin failures++; $display("FAIL load_fwd: got %0d want 2", bus.fwd_sel1); end
        tick();
        // Bubble reaches writeback: the stalled cycle must not appear as a write.
        set_in(0, 0, 0, 0, 0, 0, 0);
        checks++; if (bus.wb_en !== 1'b0) begin failures++; $display("FAIL load_bubble_wb: got %0b want 0", bus.wb_en); end
        tick();
    endtask

    task automatic test_flush();
        int pf0;
        idle(3);
        pf0 = perf_f;
        set_in(0, 0, 0, 0, 0, 0, 1);
        checks++; if (bus.kill !== 1'b0) begin failures++; $display("FAIL flush_pre: got %0b want 0", bus.kill); end
        tick();
        for (int i = 0; i < 2; i++) begin
            set_in(1, 0, 0, 9, 1, 0, 0);
            checks++; if (bus.kill !== 1'b1) begin failures++; $display("FAIL flush_kill%0d: got %0b want 1", i, bus.kill); end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0);
            checks++; if (bus.wb_en !== 1'b0) begin failures++; $display("FAIL flush_wb%0d: got %0b want 0", i, bus.wb_en); end
            if (i == 0) begin
                checks++; if (bus.kill !== 1'b0) begin failures++; $display("FAIL flush_end: got %0b want 0", bus.kill); end
                checks++; if (bus.perf_flush !== (PERF_ON ? 32'(pf0 + 2) : 32'd0)) begin failures++; $display("FAIL flush_perf: got %0d want %0d", bus.perf_flush, PERF_ON ? pf0 + 2 : 0); end
            end
            tick();
        end
    endtask

    task automatic test_branch_in_kill();
        idle(3);
        set_in(0, 0, 0, 0, 0, 0, 1);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 1);
        checks++; if (bus.kill !== 1'b1) begin failures++; $display("FAIL rebr_kill1: got %0b want 1", bus.kill); end
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0);
        checks++; if (bus.kill !== 1'b1) begin failures++; $display("FAIL rebr_kill2: got %0b want 1", bus.kill); end
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0);
        checks++; if (bus.kill !== 1'b0) begin failures++; $display("FAIL rebr_end: got %0b want 0", bus.kill); end
        tick();
    endtask

    task automatic test_priority();
        idle(3);
        set_in(1, 0, 0, 3, 1, 0, 0); tick();
        set_in(1, 0, 0, 3, 1, 0, 0); tick();
        set_in(1, 3, 0, 0, 1, 0, 0);
        checks++; if (bus.fwd_sel1 !== 3'd1) begin failures++; $display("FAIL prio_youngest: got %0d want 1", bus.fwd_sel1); end
        tick();
        set_in(1, 0, 0, 0, 1, 0, 0);
        checks++; if (bus.fwd_sel1 !== 3'd0 || bus.fwd_sel2 !== 3'd0) begin failures++; $display("FAIL prio_x0: got %0d/%0d want 0/0", bus.fwd_sel1, bus.fwd_sel2); end
        tick();
    endtask

    task automatic test_reset_mid();
        idle(3);
        set_in(1, 0, 0, 7, 1, 1, 1);
        tick();
        set_in(1, 7, 0, 0, 0, 0, 0);
        checks++; if (bus.kill !== 1'b1 || bus.stall !== 1'b0) begin failures++; $display("FAIL kill_over_stall: got kill=%0b stall=%0b want 1/0", bus.kill, bus.stall); end
        rst = 1'b1;
        #1;
        checks++; if (bus.kill !== 1'b0) begin failures++; $display("FAIL rstmid_kill: got %0b want 0", bus.kill); end
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL rstmid_stall: got %0b want 0", bus.stall); end
        checks++; if (bus.wb_en !== 1'b0 || bus.fwd_sel1 !== 3'd0) begin failures++; $display("FAIL rstmid_pipe: got wb=%0b fwd=%0d want 0/0", bus.wb_en, bus.fwd_sel1); end
        checks++; if (bus.perf_stall !== 32'd0 || bus.perf_flush !== 32'd0) begin failures++; $display("FAIL rstmid_perf: got %0d/%0d want 0/0", bus.perf_stall, bus.perf_flush); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            set_in(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                   1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0));
            checks++; if (bus.kill !== e_kill) begin failures++; $display("FAIL rnd_kill @%0d: got %0b want %0b", n, bus.kill, e_kill); end
            checks++; if (bus.stall !== e_stall) begin failures++; $display("FAIL rnd_stall @%0d: got %0b want %0b", n, bus.stall, e_stall); end
            checks++; if (bus.fwd_sel1 !== e_f1 || bus.fwd_sel2 !== e_f2) begin failures++; $display("FAIL rnd_fwd @%0d: got %0d/%0d want %0d/%0d", n, bus.fwd_sel1, bus.fwd_sel2, e_f1, e_f2); end
            checks++; if (bus.wb_en !== e_wb || bus.wb_rd !== e_wbrd) begin failures++; $display("FAIL rnd_wb @%0d: got %0b/%0d want %0b/%0d", n, bus.wb_en, bus.wb_rd, e_wb, e_wbrd); end
            checks++; if (bus.perf_stall !== (PERF_ON ? 32'(perf_s) : 32'd0) || bus.perf_flush !== (PERF_ON ? 32'(perf_f) : 32'd0)) begin failures++; $display("FAIL rnd_perf @%0d: got %0d/%0d want %0d/%0d", n, bus.perf_stall, bus.perf_flush, PERF_ON ? perf_s : 0, PERF_ON ? perf_f : 0); end
            tick();
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_fwd_alu();
        test_load_stall();
        test_flush();
        test_branch_in_kill();
        test_priority();
        test_random();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
